// File: rtl/div_unit.sv
// Multi-cycle restoring divider (signed/unsigned) for the EX stage: one quotient bit per
// cycle, result {remainder, quotient} held until the next completed operation.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs, quo, rem;
    logic             neg_quo, neg_rem;

    logic             accept, last_iter, load_div, load_zero;
    logic             op1_neg, op2_neg, fits;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub, rem_new, quo_new, quo_fin, rem_fin;

    assign accept    = (state == IDLE) && start_i && !annul_i;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign load_div  = (state == ON) && !annul_i && last_iter;
    assign load_zero = (state == BYZERO) && !annul_i;
    assign busy_o    = (state != IDLE);

    // Signed operands are reduced to magnitudes; the most-negative value maps onto itself
    // as an unsigned magnitude, which is exactly what the overflow case needs.
    assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

    // One restoring step: shift the next dividend bit into the partial remainder, subtract
    // the divisor if it fits. The true difference is below 2^WIDTH whenever it is kept.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign fits    = (rem_sh >= {1'b0, dvs});
    assign rem_sub = rem_sh[WIDTH-1:0] - dvs;
    assign rem_new = fits ? rem_sub : rem_sh[WIDTH-1:0];
    assign quo_new = {quo[WIDTH-2:0], fits};
    assign quo_fin = neg_quo ? -quo_new : quo_new;
    assign rem_fin = neg_rem ? -rem_new : rem_new;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (start_i && !annul_i) state_next = (opdata2_i == '0) ? BYZERO : ON;
            BYZERO:  state_next = annul_i ? IDLE : END;
            ON: begin
                if (annul_i)        state_next = IDLE;
                else if (last_iter) state_next = END;
            end
            END:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            result_o   <= '0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            state   <= state_next;
            ready_o <= (state == END);
            cnt     <= ((state == ON) && !annul_i && !last_iter) ? cnt + 1'b1 : '0;
            if (load_div) begin
                result_o   <= {rem_fin, quo_fin};
                div_zero_o <= 1'b0;
            end else if (load_zero) begin
                result_o   <= '0;
                div_zero_o <= 1'b1;
            end
        end
    end

    // NOTE: working registers are reset-less; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvs     <= op2_mag;
            quo     <= op1_mag;
            rem     <= '0;
            neg_quo <= op1_neg ^ op2_neg;
            neg_rem <= op1_neg;
        end else if (state == ON) begin
            quo <= quo_new;
            rem <= rem_new;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes hand-computed results with their expected
// ready edge; a negedge monitor pops and compares on every ready_o pulse.
module tb_div_unit;

    localparam int W = 32;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        dz;
        int          edge_no;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          annul_i = 1'b0;
    logic          signed_div_i = 1'b0;
    logic [W-1:0]  opdata1_i = '0;
    logic [W-1:0]  opdata2_i = '0;
    logic [2*W-1:0] result_o;
    logic          ready_o, busy_o, div_zero_o;

    int   edge_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t mon_e;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && ready_o) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ready: pulse at edge %0d, result %h", edge_cnt, result_o);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, result_o, mon_e.res);
                check({mon_e.name, "_div_zero"}, 64'(div_zero_o), 64'(mon_e.dz));
                check({mon_e.name, "_latency"}, 64'(edge_cnt), 64'(mon_e.edge_no));
            end
        end
    end

    task automatic wait_until_edge(input int target);
        while (edge_cnt < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one start; operands and mode are scrambled right after the sampling edge.
    task automatic issue(input string name, input logic sgn, input logic [W-1:0] a, b,
                         input logic [W-1:0] q, r, input logic dz, input bit expect_done,
                         output int s_edge);
        @(negedge clk);
        start_i = 1'b1; signed_div_i = sgn; opdata1_i = a; opdata2_i = b;
        @(posedge clk);
        #1;
        s_edge = edge_cnt;
        if (expect_done) sb.push_back('{name, {r, q}, dz, s_edge + ((b == 0) ? 2 : W + 1)});
        start_i = 1'b0; signed_div_i = ~sgn; opdata1_i = ~a; opdata2_i = b + 32'd5;
        check({name, "_busy_after_start"}, 64'(busy_o), 64'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy_o) && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) begin
            n_total++;
            $display("FAIL %s_timeout: %0d results outstanding, busy %0b", name, sb.size(), busy_o);
        end
    endtask

    task automatic run(input string name, input logic sgn, input logic [W-1:0] a, b,
                       input logic [W-1:0] q, r, input logic dz);
        int s;
        issue(name, sgn, a, b, q, r, dz, 1'b1, s);
        drain(name);
    endtask

    initial begin
        int s;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        #23;
        check("reset_result", result_o, 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_div_zero", 64'(div_zero_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // 100/7 with busy observed in the END cycle
        issue("u100_7", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0, 1'b1, s);
        wait_until_edge(s + W);
        check("u100_7_busy_in_end", 64'(busy_o), 64'd1);
        check("u100_7_no_early_ready", 64'(ready_o), 64'd0);
        drain("u100_7");

        run("s_m7_2",    1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run("u_m7_2",    1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0);
        run("s_7_m2",    1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
        run("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 1'b0);
        run("u_max_1",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run("u_3_10",    1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         1'b0);
        run("u_5_0",     1'b0, 32'd5,         32'd0,         32'd0,         32'd0,         1'b1);

        // annul while in BYZERO: no pulse, previous divide-by-zero result retained
        issue("annul_byzero", 1'b0, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, s);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul_byzero_busy", 64'(busy_o), 64'd0);
        check("annul_byzero_div_zero_kept", 64'(div_zero_o), 64'd1);
        repeat (5) @(negedge clk);

        run("u_9_3",     1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0);
        run("s_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);

        // annul at iteration 10
        issue("annul_on", 1'b0, 32'd123456, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, s);
        wait_until_edge(s + 10);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul_on_busy", 64'(busy_o), 64'd0);
        check("annul_on_result_kept", result_o, {32'h0, 32'h8000_0000});
        repeat (40) @(negedge clk);
        run("u_50_5",    1'b0, 32'd50,        32'd5,         32'd10,        32'd0,         1'b0);

        // start held high: re-accepted in the IDLE cycle after END, ignored while busy
        @(negedge clk);
        start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd4;
        @(posedge clk);
        #1;
        s = edge_cnt;
        sb.push_back('{"b2b_first", {32'd0, 32'd5}, 1'b0, s + W + 1});
        wait_until_edge(s + W + 2);
        sb.push_back('{"b2b_second", {32'd0, 32'd5}, 1'b0, s + 2 * W + 3});
        check("b2b_reaccept_busy", 64'(busy_o), 64'd1);
        start_i = 1'b0; opdata1_i = 32'd99; opdata2_i = 32'd2;
        drain("b2b");

        // asynchronous reset at iteration 20
        issue("rst_mid", 1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, s);
        wait_until_edge(s + 20);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_result", result_o, 64'd0);
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        check("rst_mid_div_zero", 64'(div_zero_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run("s_m50_7",   1'b1, 32'hFFFF_FFCE, 32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
